// File: rtl/pulse_stretch_bank.sv
// pulse_stretch_bank
//   A bank of independent button channels. Each channel synchronises a raw
//   button level, debounces it, and turns every accepted rising edge into a
//   stretched pulse. The per-channel mode selects how a channel responds.
//
//   Ports
//     clk        single clock for all logic
//     reset      synchronous, active-high reset
//     btn        [CHANNELS]   asynchronous raw button levels
//     mode       [2*CHANNELS] per-channel mode, bits [2i+1:2i] for channel i
//                  00 one-shot, 01 retrigger, 10 auto-repeat, 11 level pass-through
//     pulse_out  [CHANNELS]   stretched trigger output (registered)
//     edge_out   [CHANNELS]   one-cycle strobe per accepted rising edge (registered)

// pulse_stretch_chan
//   One channel of the bank: 2-flop synchroniser, debounce, pulse counter,
//   auto-repeat counter and registered mode.
//
//   Ports
//     clk, reset  shared clock and synchronous active-high reset
//     btn         raw button level for this channel
//     mode        2-bit mode for this channel
//     pulse_out   stretched pulse (or debounced level in mode 11)
//     edge_out    one-cycle strobe per serviced rising edge
module pulse_stretch_chan #(
    parameter int          CW            = 24,
    parameter int unsigned PULSE_LEN     = 24'hFFFFF,
    parameter int          DEBOUNCE      = 1,
    parameter int unsigned REPEAT_DELAY  = 24'h3FFFFF,
    parameter int unsigned REPEAT_PERIOD = 24'h1FFFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic [1:0] mode,
    output logic       pulse_out,
    output logic       edge_out
);

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RETRIG  = 2'b01;
    localparam logic [1:0] MODE_REPEAT  = 2'b10;
    localparam logic [1:0] MODE_LEVEL   = 2'b11;

    // Stability counter only has to reach DEBOUNCE-1.
    localparam int SW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [CW-1:0] PLEN = CW'(PULSE_LEN);
    localparam logic [CW-1:0] RDLY = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RPER = CW'(REPEAT_PERIOD);
    localparam logic [SW-1:0] STAB_LAST = SW'(DEBOUNCE - 1);

    logic          s1;
    logic          s2;
    logic          lvl;
    logic [SW-1:0] stab;
    logic [CW-1:0] cnt;
    logic [CW-1:0] rpt;
    logic [1:0]    mode_r;

    logic          lvl_nxt;
    logic [SW-1:0] stab_nxt;
    logic          rise;
    logic          busy;
    logic          take;
    logic          mode_chg;
    logic [1:0]    mode_eff;
    logic [CW-1:0] cnt_dec;
    logic [CW-1:0] rpt_dec;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] rpt_nxt;
    logic          pulse_nxt;

    // Debounce: lvl follows s2 only once s2 has disagreed with it for
    // DEBOUNCE consecutive edges; any agreement restarts the count.
    always_comb begin
        lvl_nxt  = lvl;
        stab_nxt = '0;
        rise     = 1'b0;
        if (s2 != lvl) begin
            if (stab == STAB_LAST) begin
                lvl_nxt = s2;
                rise    = s2;
            end else begin
                stab_nxt = stab + SW'(1);
            end
        end
    end

    // Pulse / repeat counters. Both saturate at zero.
    always_comb begin
        busy     = (cnt != '0);
        cnt_dec  = busy ? (cnt - CW'(1)) : '0;
        rpt_dec  = (rpt != '0) ? (rpt - CW'(1)) : '0;
        mode_chg = (mode != mode_r);
        mode_eff = mode_chg ? mode : mode_r;
        take     = rise;
        cnt_nxt  = cnt_dec;
        rpt_nxt  = '0;

        case (mode_r)
            MODE_ONESHOT: begin
                // Edges during an active pulse are dropped entirely.
                take = rise & ~busy;
                if (take) cnt_nxt = PLEN;
            end
            MODE_RETRIG: begin
                if (rise) cnt_nxt = PLEN;
            end
            MODE_REPEAT: begin
                if (rise) begin
                    cnt_nxt = PLEN;
                    rpt_nxt = RDLY;
                end else if (lvl) begin
                    // Held button: count down, fire and re-arm on reaching 1.
                    if (rpt == CW'(1)) begin
                        cnt_nxt = PLEN;
                        rpt_nxt = RPER;
                    end else begin
                        rpt_nxt = rpt_dec;
                    end
                end
                // lvl low leaves rpt_nxt at 0; the running pulse finishes.
            end
            default: begin
                // Level pass-through keeps both counters idle.
                cnt_nxt = '0;
            end
        endcase

        // A mode change aborts whatever was running and swallows this edge.
        if (mode_chg) begin
            cnt_nxt = '0;
            rpt_nxt = '0;
            take    = 1'b0;
        end

        pulse_nxt = (mode_eff == MODE_LEVEL) ? lvl_nxt : (cnt_nxt != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            lvl       <= 1'b0;
            stab      <= '0;
            cnt       <= '0;
            rpt       <= '0;
            mode_r    <= mode;
            pulse_out <= 1'b0;
            edge_out  <= 1'b0;
        end else begin
            s1        <= btn;
            s2        <= s1;
            lvl       <= lvl_nxt;
            stab      <= stab_nxt;
            cnt       <= cnt_nxt;
            rpt       <= rpt_nxt;
            mode_r    <= mode;
            pulse_out <= pulse_nxt;
            edge_out  <= take;
        end
    end

endmodule

module pulse_stretch_bank #(
    parameter int          CHANNELS      = 4,
    parameter int          CW            = 24,
    parameter int unsigned PULSE_LEN     = 24'hFFFFF,
    parameter int          DEBOUNCE      = 1,
    parameter int unsigned REPEAT_DELAY  = 24'h3FFFFF,
    parameter int unsigned REPEAT_PERIOD = 24'h1FFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   btn,
    input  logic [2*CHANNELS-1:0] mode,
    output logic [CHANNELS-1:0]   pulse_out,
    output logic [CHANNELS-1:0]   edge_out
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pulse_stretch_chan #(
            .CW            (CW),
            .PULSE_LEN     (PULSE_LEN),
            .DEBOUNCE      (DEBOUNCE),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .btn       (btn[i]),
            .mode      (mode[2*i +: 2]),
            .pulse_out (pulse_out[i]),
            .edge_out  (edge_out[i])
        );
    end

endmodule

// File: tb/tb_pulse_stretch_bank.sv
// Testbench for pulse_stretch_bank. Directed scenarios push hand-computed
// expected {pulse_out, edge_out} per cycle into a scoreboard; a monitor on
// the falling edge pops and compares entries as their cycle comes up.
// Cycle numbering: "after edge n" is sampled at the negedge where cyc==n,
// relative to the scenario base (reset sampled low from edge 1).
module tb_pulse_stretch_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] btn_a = '0;
    logic [1:0] btn_b = '0;
    logic [3:0] mode_a = '0;
    logic [3:0] mode_b = '0;
    logic [1:0] pulse_a, edge_a, pulse_b, edge_b;

    // DUT A: main configuration. DUT B: long debounce, zero-length pulse.
    pulse_stretch_bank #(
        .CHANNELS(2), .CW(8), .PULSE_LEN(5), .DEBOUNCE(1),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut_a (
        .clk(clk), .reset(reset), .btn(btn_a), .mode(mode_a),
        .pulse_out(pulse_a), .edge_out(edge_a)
    );

    pulse_stretch_bank #(
        .CHANNELS(2), .CW(8), .PULSE_LEN(0), .DEBOUNCE(4),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
    ) dut_b (
        .clk(clk), .reset(reset), .btn(btn_b), .mode(mode_b),
        .pulse_out(pulse_b), .edge_out(edge_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         dut;
        logic [1:0] pulse;
        logic [1:0] edg;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   base     = 0;

    // Monitor: compare every entry due this cycle; anything overdue is a miss.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                logic [1:0] ap, ae;
                ap = sb[i].dut ? pulse_b : pulse_a;
                ae = sb[i].dut ? edge_b  : edge_a;
                n_checks++;
                if (ap === sb[i].pulse && ae === sb[i].edg)
                    n_pass++;
                else
                    $display("FAIL %s cyc=%0d rel=%0d actual pulse=%b edge=%b required pulse=%b edge=%b",
                             sb[i].name, cyc, cyc - base, ap, ae, sb[i].pulse, sb[i].edg);
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                n_checks++;
                $display("FAIL %s missed check at cyc=%0d", sb[i].name, sb[i].cyc);
                sb.delete(i);
            end
        end
    end

    task automatic push_abs(input string nm, input bit d, input int c,
                            input logic [1:0] p, input logic [1:0] e);
        exp_t x;
        x.cyc = c; x.dut = d; x.pulse = p; x.edg = e; x.name = nm;
        sb.push_back(x);
    endtask

    task automatic push_exp(input string nm, input bit d, input int n,
                            input logic [1:0] p, input logic [1:0] e);
        push_abs(nm, d, base + n, p, e);
    endtask

    function automatic logic inr(input int n, input int a, input int b);
        return (n >= a) && (n <= b);
    endfunction

    // Wait until the negedge after relative edge n.
    task automatic at(input int n);
        while (cyc < base + n) @(negedge clk);
    endtask

    // Reset both DUTs for two edges with the given modes; outputs must be 0.
    task automatic start_scn(input logic [3:0] ma, input logic [3:0] mb);
        @(negedge clk);
        btn_a = '0; btn_b = '0; mode_a = ma; mode_b = mb; reset = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            push_abs("reset_a", 1'b0, cyc + k, 2'b00, 2'b00);
            push_abs("reset_b", 1'b1, cyc + k, 2'b00, 2'b00);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        base  = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        // One-shot, single press on channel 0.
        start_scn(4'b0000, 4'b0000);
        for (int n = 1; n <= 25; n++)
            push_exp("oneshot", 1'b0, n, {1'b0, inr(n, 12, 16)}, {1'b0, n == 12});
        at(9);  btn_a = 2'b01;
        at(11); btn_a = 2'b00;
        at(26);

        // Second edge at 15: ch0 one-shot ignores it, ch1 retrigger extends.
        start_scn(4'b0100, 4'b0000);
        for (int n = 1; n <= 25; n++)
            push_exp("retrig", 1'b0, n,
                     {inr(n, 12, 19), inr(n, 12, 16)},
                     {(n == 12) || (n == 15), n == 12});
        at(9);  btn_a = 2'b11;
        at(11); btn_a = 2'b00;
        at(12); btn_a = 2'b11;
        at(14); btn_a = 2'b00;
        at(26);

        // ch0 auto-repeat held 10..59, ch1 level pass-through held 20..29.
        start_scn(4'b1110, 4'b0000);
        for (int n = 1; n <= 75; n++)
            push_exp("repeat_level", 1'b0, n,
                     {inr(n, 22, 31),
                      inr(n, 12, 16) || inr(n, 32, 36) || inr(n, 40, 44) ||
                      inr(n, 48, 52) || inr(n, 56, 60)},
                     {n == 22, n == 12});
        at(9);  btn_a[0] = 1'b1;
        at(19); btn_a[1] = 1'b1;
        at(29); btn_a[1] = 1'b0;
        at(59); btn_a[0] = 1'b0;
        at(76);

        // Reset mid-pulse with button held; re-accepted at 17.
        start_scn(4'b0000, 4'b0000);
        for (int n = 1; n <= 30; n++)
            push_exp("mid_reset", 1'b0, n,
                     {1'b0, inr(n, 12, 13) || inr(n, 17, 21)},
                     {1'b0, (n == 12) || (n == 17)});
        at(9);  btn_a = 2'b01;
        at(13); reset = 1'b1;
        at(14); reset = 1'b0;
        at(31);

        // Mode change at edge 14: ch0 01->00 kills pulse, ch1 01->11 follows lvl.
        start_scn(4'b0101, 4'b0000);
        for (int n = 1; n <= 25; n++)
            push_exp("mode_chg", 1'b0, n,
                     {inr(n, 12, 25), inr(n, 12, 13)},
                     {n == 12, n == 12});
        at(9);  btn_a = 2'b11;
        at(10); btn_a[0] = 1'b0;
        at(13); mode_a = 4'b1100;
        at(26);

        // DUT B: bouncing input rejected, hold from 30 accepted at 35,
        // zero pulse length never raises pulse_out (one-shot and repeat).
        start_scn(4'b0000, 4'b1000);
        for (int n = 1; n <= 60; n++)
            push_exp("debounce", 1'b1, n, 2'b00, {n == 35, n == 35});
        for (int k = 10; k <= 30; k++) begin
            at(k - 1);
            btn_b = ((k >= 30) || (((k - 10) % 4) < 2)) ? 2'b11 : 2'b00;
        end
        at(61);

        repeat (3) @(negedge clk);
        while (sb.size() > 0) begin
            n_checks++;
            $display("FAIL %s never checked (cyc=%0d)", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
